// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, LSB slice first.
// Start/busy/done handshake; diff, bout and ovf are held until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int L     = WIDTH / DIGIT;
    localparam int CNT_W = (L > 1) ? $clog2(L) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT >= 1");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   a_q, b_q, res_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               borrow_q;
    logic               a_sign_q, b_sign_q;
    logic               busy_q, done_q, bout_q, ovf_q;
    logic [WIDTH-1:0]   diff_q;

    logic [DIGIT:0]       slice;
    logic [WIDTH+DIGIT-1:0] res_wide;
    logic [WIDTH-1:0]     res_d;
    logic                 borrow_d;
    logic                 last;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        slice    = '0;
        res_wide = '0;
        res_d    = '0;
        borrow_d = 1'b0;
        last     = 1'b0;

        slice    = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};
        borrow_d = slice[DIGIT];
        res_wide = {slice[DIGIT-1:0], res_q};
        res_d    = res_wide[WIDTH+DIGIT-1:DIGIT];
        last     = (cnt_q == CNT_W'(L - 1));
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    a_q      <= a;
                    b_q      <= b;
                    a_sign_q <= a[WIDTH-1];
                    b_sign_q <= b[WIDTH-1];
                    borrow_q <= bin;
                    cnt_q    <= '0;
                    busy_q   <= 1'b1;
                    state_q  <= RUN;
                end
            end else begin
                a_q      <= a_q >> DIGIT;
                b_q      <= b_q >> DIGIT;
                res_q    <= res_d;
                borrow_q <= borrow_d;
                cnt_q    <= cnt_q + 1'b1;
                if (last) begin
                    diff_q  <= res_d;
                    bout_q  <= borrow_d;
                    // Operands of differing sign whose result sign differs from a: out of range.
                    ovf_q   <= (a_sign_q ^ b_sign_q) & (a_sign_q ^ res_d[WIDTH-1]);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8x1 and a 16x4 instance, expected
// results queued at start and compared by a monitor when done pulses.
module tb_serial_subtractor;

    typedef struct {
        int d;
        bit bo;
        bit ov;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        start8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0]  a8, b8, diff8;
    logic        start16, bin16, busy16, done16, bout16, ovf16;
    logic [15:0] a16, b16, diff16;

    int   n_checks = 0;
    int   n_fails  = 0;
    exp_t q8[$];
    exp_t q16[$];

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .ovf(ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model in plain integer arithmetic, independent of the digit-serial structure.
    function automatic void model(input int w, input int av, input int bv, input int bi,
                                  output int d, output bit bo, output bit ov);
        int r, sa, sb, s;
        r  = av - bv - bi;
        bo = (r < 0);
        d  = r & ((1 << w) - 1);
        sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
        sb = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
        s  = sa - sb - bi;
        ov = (s < -(1 << (w - 1))) || (s > (1 << (w - 1)) - 1);
    endfunction

    always @(negedge clk) begin
        if (done8 === 1'b1) begin : mon8
            exp_t e;
            n_checks++;
            if (q8.size() == 0) begin
                n_fails++;
                $display("FAIL done8_unexpected: got done=1 diff=%h, required no completion", diff8);
            end else begin
                e = q8.pop_front();
                if (diff8 !== e.d[7:0] || bout8 !== e.bo || ovf8 !== e.ov) begin
                    n_fails++;
                    $display("FAIL result8: got diff=%h bout=%b ovf=%b, required diff=%h bout=%b ovf=%b",
                             diff8, bout8, ovf8, e.d[7:0], e.bo, e.ov);
                end
            end
        end
        if (done16 === 1'b1) begin : mon16
            exp_t e;
            n_checks++;
            if (q16.size() == 0) begin
                n_fails++;
                $display("FAIL done16_unexpected: got done=1 diff=%h, required no completion", diff16);
            end else begin
                e = q16.pop_front();
                if (diff16 !== e.d[15:0] || bout16 !== e.bo || ovf16 !== e.ov) begin
                    n_fails++;
                    $display("FAIL result16: got diff=%h bout=%b ovf=%b, required diff=%h bout=%b ovf=%b",
                             diff16, bout16, ovf16, e.d[15:0], e.bo, e.ov);
                end
            end
        end
    end

    // Called at a negedge; the start edge is the next posedge. Returns at the negedge after done.
    // inject: cycle at which a competing start is pulsed; hold: diff must keep hold_val until done.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        input int inject, input bit hold, input logic [7:0] hold_val);
        exp_t e;
        model(8, av, bv, bi, e.d, e.bo, e.ov);
        q8.push_back(e);
        start8 = 1'b1; a8 = av; b8 = bv; bin8 = bi;
        for (int n = 0; n <= 8; n++) begin
            if (n > 0 && n == inject) begin
                start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
            end
            @(negedge clk);
            start8 = 1'b0;
            if (n == 0) begin
                a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            end
            n_checks++;
            if (busy8 !== (n < 8) || done8 !== (n == 8)) begin
                n_fails++;
                $display("FAIL latency8 edge %0d: got busy=%b done=%b, required busy=%b done=%b",
                         n, busy8, done8, n < 8, n == 8);
            end
            if (hold && n < 8) begin
                n_checks++;
                if (diff8 !== hold_val) begin
                    n_fails++;
                    $display("FAIL hold8 edge %0d: got diff=%h, required %h", n, diff8, hold_val);
                end
            end
        end
    endtask

    task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic bi);
        exp_t e;
        model(16, av, bv, bi, e.d, e.bo, e.ov);
        q16.push_back(e);
        start16 = 1'b1; a16 = av; b16 = bv; bin16 = bi;
        for (int n = 0; n <= 4; n++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (n == 0) begin
                a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
            end
            n_checks++;
            if (busy16 !== (n < 4) || done16 !== (n == 4)) begin
                n_fails++;
                $display("FAIL latency16 edge %0d: got busy=%b done=%b, required busy=%b done=%b",
                         n, busy16, done16, n < 4, n == 4);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy8, done8, diff8, bout8, ovf8} !== 12'h0 ||
            {busy16, done16, diff16, bout16, ovf16} !== 20'h0) begin
            n_fails++;
            $display("FAIL reset_state: got dut8 %b/%b/%h/%b/%b dut16 %b/%b/%h/%b/%b, required all zero",
                     busy8, done8, diff8, bout8, ovf8, busy16, done16, diff16, bout16, ovf16);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run8(8'h05, 8'h03, 1'b0, 0, 1'b0, 8'h00);
    endtask

    task automatic test_underflow();
        run8(8'h03, 8'h05, 1'b0, 0, 1'b0, 8'h00);
        run8(8'h00, 8'h00, 1'b1, 0, 1'b0, 8'h00);
    endtask

    task automatic test_overflow();
        run8(8'h80, 8'h01, 1'b0, 0, 1'b0, 8'h00);
        run8(8'h7F, 8'hFF, 1'b0, 0, 1'b0, 8'h00);
        run8(8'h80, 8'h00, 1'b1, 0, 1'b0, 8'h00);
    endtask

    task automatic test_start_while_busy();
        run8(8'h05, 8'h03, 1'b0, 3, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run8(8'h05, 8'h03, 1'b0, 0, 1'b0, 8'h00);
        run8(8'h10, 8'h01, 1'b0, 0, 1'b1, 8'h02);
    endtask

    task automatic test_reset_midop();
        start8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy8, done8, diff8, bout8, ovf8} !== 12'h0) begin
            n_fails++;
            $display("FAIL reset_midop: got busy=%b done=%b diff=%h bout=%b ovf=%b, required all zero",
                     busy8, done8, diff8, bout8, ovf8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            n_checks++;
            if (busy8 !== 1'b0 || done8 !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_release cycle %0d: got busy=%b done=%b, required 0/0", n, busy8, done8);
            end
        end
        run8(8'h05, 8'h03, 1'b0, 0, 1'b0, 8'h00);
    endtask

    task automatic test_wide();
        run16(16'h1234, 16'h0235, 1'b1);
        run16(16'h8000, 16'h0001, 1'b0);
        run16(16'h0000, 16'hFFFF, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_overflow();
        test_start_while_busy();
        test_back_to_back();
        test_reset_midop();
        test_wide();
        test_random();
        repeat (2) @(negedge clk);
        n_checks++;
        if (q8.size() != 0 || q16.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending results, required 0/0", q8.size(), q16.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
